// File: rtl/res_station_array_pkg.sv
// Shared Tomasulo back-end types: op encoding and default datapath widths.
package tomasula_types;

    localparam int DEFAULT_TAG_W = 3;
    localparam int DEFAULT_XLEN  = 32;
    localparam int OP_W          = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ARITH     = 3'd0,
        OP_ARITH_IMM = 3'd1,
        OP_LOAD      = 3'd2,
        OP_STORE     = 3'd3,
        OP_BRANCH    = 3'd4,
        OP_JAL       = 3'd5,
        OP_JALR      = 3'd6,
        OP_LUI       = 3'd7
    } op_t;

endpackage

// File: rtl/res_station_array_if.sv
// Dispatch, CDB snoop and issue bundle of the reservation station.
interface res_station_array_if
    import tomasula_types::*;
#(
    parameter int TAG_W   = DEFAULT_TAG_W,
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int NUM_CDB = 1
);
    logic                     disp_valid;
    logic                     disp_ready;
    op_t                      disp_op;
    logic [2:0]               disp_funct3;
    logic                     disp_funct7;
    logic [TAG_W-1:0]         disp_src1_tag, disp_src2_tag, disp_rd_tag;
    logic [XLEN-1:0]          disp_src1_data, disp_src2_data, disp_imm;
    logic                     disp_src1_valid, disp_src2_valid;

    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_data;

    logic                     iss_valid;
    logic                     iss_ready;
    op_t                      iss_op;
    logic [2:0]               iss_funct3;
    logic                     iss_funct7;
    logic [XLEN-1:0]          iss_src1_data, iss_src2_data, iss_imm;
    logic [TAG_W-1:0]         iss_tag;

    modport master (
        output disp_valid, disp_op, disp_funct3, disp_funct7,
               disp_src1_tag, disp_src2_tag, disp_rd_tag,
               disp_src1_data, disp_src2_data, disp_imm,
               disp_src1_valid, disp_src2_valid,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        input  disp_ready, iss_valid, iss_op, iss_funct3, iss_funct7,
               iss_src1_data, iss_src2_data, iss_imm, iss_tag
    );

    modport slave (
        input  disp_valid, disp_op, disp_funct3, disp_funct7,
               disp_src1_tag, disp_src2_tag, disp_rd_tag,
               disp_src1_data, disp_src2_data, disp_imm,
               disp_src1_valid, disp_src2_valid,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        output disp_ready, iss_valid, iss_op, iss_funct3, iss_funct7,
               iss_src1_data, iss_src2_data, iss_imm, iss_tag
    );

endinterface

// File: rtl/res_station_array_entry.sv
// One reservation-station word: op storage plus per-operand CDB capture.
module rs_entry
    import tomasula_types::*;
#(
    parameter int TAG_W   = DEFAULT_TAG_W,
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int NUM_CDB = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc,
    input  logic                       clear,
    input  op_t                        d_op,
    input  logic [2:0]                 d_funct3,
    input  logic                       d_funct7,
    input  logic [1:0]                 d_src_valid,
    input  logic [1:0][TAG_W-1:0]      d_src_tag,
    input  logic [1:0][XLEN-1:0]       d_src_data,
    input  logic [TAG_W-1:0]           d_rd_tag,
    input  logic [XLEN-1:0]            d_imm,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]    cdb_data,
    output logic                       busy,
    output logic                       ready,
    output op_t                        op,
    output logic [2:0]                 funct3,
    output logic                       funct7,
    output logic [1:0][XLEN-1:0]       src_data,
    output logic [XLEN-1:0]            imm,
    output logic [TAG_W-1:0]           rd_tag
);
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } opnd_t;

    opnd_t [1:0]            src_q;
    logic  [1:0][TAG_W-1:0] cmp_tag;
    logic  [1:0]            hit;
    logic  [1:0][XLEN-1:0]  hit_data;

    // During allocation the incoming tag is matched instead of the stored
    // one, which gives the dispatch bypass. Lowest channel wins on overlap.
    always_comb begin
        cmp_tag  = '0;
        hit      = '0;
        hit_data = '0;
        for (int s = 0; s < 2; s++) begin
            cmp_tag[s] = alloc ? d_src_tag[s] : src_q[s].tag;
            for (int c = NUM_CDB-1; c >= 0; c--) begin
                if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == cmp_tag[s]) begin
                    hit[s]      = 1'b1;
                    hit_data[s] = cdb_data[c*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy   <= 1'b0;
            src_q  <= '0;
            op     <= OP_ARITH;
            funct3 <= '0;
            funct7 <= 1'b0;
            imm    <= '0;
            rd_tag <= '0;
        end else if (flush) begin
            busy <= 1'b0;
        end else if (alloc) begin
            busy   <= 1'b1;
            op     <= d_op;
            funct3 <= d_funct3;
            funct7 <= d_funct7;
            imm    <= d_imm;
            rd_tag <= d_rd_tag;
            for (int s = 0; s < 2; s++) begin
                src_q[s].tag   <= d_src_tag[s];
                src_q[s].valid <= d_src_valid[s] | hit[s];
                src_q[s].data  <= d_src_valid[s] ? d_src_data[s] : hit_data[s];
            end
        end else begin
            if (clear)
                busy <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                if (!src_q[s].valid && hit[s]) begin
                    src_q[s].valid <= 1'b1;
                    src_q[s].data  <= hit_data[s];
                end
            end
        end
    end

    assign ready    = busy & src_q[0].valid & src_q[1].valid;
    assign src_data = {src_q[1].data, src_q[0].data};

endmodule

// File: rtl/res_station_array.sv
// Reservation station: DEPTH entries, NUM_CDB wakeup buses, one locked
// valid/ready issue port and a synchronous flush.
module res_station_array
    import tomasula_types::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = DEFAULT_TAG_W,
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int NUM_CDB = 1,
    parameter int OCC_W   = $clog2(DEPTH+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    res_station_array_if.slave bus,
    output logic [OCC_W-1:0]   occupancy
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]                 ent_busy, ent_ready, ent_alloc, ent_clear;
    op_t  [DEPTH-1:0]                 ent_op;
    logic [DEPTH-1:0][2:0]            ent_funct3;
    logic [DEPTH-1:0]                 ent_funct7;
    logic [DEPTH-1:0][1:0][XLEN-1:0]  ent_src;
    logic [DEPTH-1:0][XLEN-1:0]       ent_imm;
    logic [DEPTH-1:0][TAG_W-1:0]      ent_rd;

    logic [OCC_W-1:0] occ_q;
    logic             lock_vld;
    logic [IDX_W-1:0] lock_idx, free_idx, rdy_idx, sel_idx;
    logic             disp_fire, iss_fire, cdb_dup;

    // Readiness comes from registered occupancy only, so a slot freed by
    // this cycle's issue is reused no earlier than next cycle.
    assign bus.disp_ready = (occ_q < OCC_W'(DEPTH));
    assign disp_fire      = bus.disp_valid & bus.disp_ready;
    assign bus.iss_valid  = lock_vld | (|ent_ready);
    assign iss_fire       = bus.iss_valid & bus.iss_ready;
    assign sel_idx        = lock_vld ? lock_idx : rdy_idx;
    assign occupancy      = occ_q;

    always_comb begin
        free_idx = '0;
        rdy_idx  = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!ent_busy[i]) free_idx = IDX_W'(i);
            if (ent_ready[i]) rdy_idx  = IDX_W'(i);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign ent_alloc[g] = disp_fire && (free_idx == IDX_W'(g));
        assign ent_clear[g] = iss_fire  && (sel_idx  == IDX_W'(g));

        rs_entry #(.TAG_W(TAG_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB)) u_ent (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush),
            .alloc       (ent_alloc[g]),
            .clear       (ent_clear[g]),
            .d_op        (bus.disp_op),
            .d_funct3    (bus.disp_funct3),
            .d_funct7    (bus.disp_funct7),
            .d_src_valid ({bus.disp_src2_valid, bus.disp_src1_valid}),
            .d_src_tag   ({bus.disp_src2_tag, bus.disp_src1_tag}),
            .d_src_data  ({bus.disp_src2_data, bus.disp_src1_data}),
            .d_rd_tag    (bus.disp_rd_tag),
            .d_imm       (bus.disp_imm),
            .cdb_valid   (bus.cdb_valid),
            .cdb_tag     (bus.cdb_tag),
            .cdb_data    (bus.cdb_data),
            .busy        (ent_busy[g]),
            .ready       (ent_ready[g]),
            .op          (ent_op[g]),
            .funct3      (ent_funct3[g]),
            .funct7      (ent_funct7[g]),
            .src_data    (ent_src[g]),
            .imm         (ent_imm[g]),
            .rd_tag      (ent_rd[g])
        );
    end

    // Issue payload is a pure mux of entry registers, zeroed when idle.
    always_comb begin
        bus.iss_op        = OP_ARITH;
        bus.iss_funct3    = '0;
        bus.iss_funct7    = 1'b0;
        bus.iss_src1_data = '0;
        bus.iss_src2_data = '0;
        bus.iss_imm       = '0;
        bus.iss_tag       = '0;
        if (bus.iss_valid) begin
            bus.iss_op        = ent_op[sel_idx];
            bus.iss_funct3    = ent_funct3[sel_idx];
            bus.iss_funct7    = ent_funct7[sel_idx];
            bus.iss_src1_data = ent_src[sel_idx][0];
            bus.iss_src2_data = ent_src[sel_idx][1];
            bus.iss_imm       = ent_imm[sel_idx];
            bus.iss_tag       = ent_rd[sel_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q    <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
        end else if (flush) begin
            occ_q    <= '0;
            lock_vld <= 1'b0;
        end else begin
            occ_q <= occ_q + OCC_W'(disp_fire) - OCC_W'(iss_fire);
            if (iss_fire) begin
                lock_vld <= 1'b0;
            end else if (bus.iss_valid) begin
                lock_vld <= 1'b1;
                lock_idx <= sel_idx;
            end
        end
    end

    always_comb begin
        cdb_dup = 1'b0;
        for (int a = 0; a < NUM_CDB; a++)
            for (int b = a + 1; b < NUM_CDB; b++)
                if (bus.cdb_valid[a] && bus.cdb_valid[b] &&
                    bus.cdb_tag[a*TAG_W +: TAG_W] == bus.cdb_tag[b*TAG_W +: TAG_W])
                    cdb_dup = 1'b1;
    end

    a_cdb_unique_tag: assert property (@(posedge clk) disable iff (!rst) !cdb_dup);

endmodule

// File: tb/tb_res_station_array.sv
// Directed bench for res_station_array with an issue-order scoreboard.
module tb_res_station_array;
    import tomasula_types::*;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 3;
    localparam int XLEN    = 32;
    localparam int NUM_CDB = 2;
    localparam int OCC_W   = $clog2(DEPTH+1);

    typedef struct packed {
        op_t              op;
        logic [2:0]       funct3;
        logic             funct7;
        logic [XLEN-1:0]  src1;
        logic [XLEN-1:0]  src2;
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush = 1'b0;
    logic [OCC_W-1:0] occupancy;
    int               n_chk = 0;
    int               n_fail = 0;
    exp_t             exp_q[$];
    exp_t             mon_act, mon_exp;

    res_station_array_if #(.TAG_W(TAG_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB)) bus ();

    res_station_array #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_valid      = 1'b0;
        bus.disp_op         = OP_ARITH;
        bus.disp_funct3     = '0;
        bus.disp_funct7     = 1'b0;
        bus.disp_src1_tag   = '0;
        bus.disp_src2_tag   = '0;
        bus.disp_rd_tag     = '0;
        bus.disp_src1_data  = '0;
        bus.disp_src2_data  = '0;
        bus.disp_imm        = '0;
        bus.disp_src1_valid = 1'b0;
        bus.disp_src2_valid = 1'b0;
        bus.cdb_valid       = '0;
        bus.cdb_tag         = '0;
        bus.cdb_data        = '0;
    endtask

    task automatic disp(input op_t op, input logic [2:0] f3, input logic f7,
                        input logic v1, input logic [TAG_W-1:0] t1, input logic [XLEN-1:0] d1,
                        input logic v2, input logic [TAG_W-1:0] t2, input logic [XLEN-1:0] d2,
                        input logic [TAG_W-1:0] rd, input logic [XLEN-1:0] imm);
        bus.disp_valid      = 1'b1;
        bus.disp_op         = op;
        bus.disp_funct3     = f3;
        bus.disp_funct7     = f7;
        bus.disp_src1_valid = v1;
        bus.disp_src1_tag   = t1;
        bus.disp_src1_data  = d1;
        bus.disp_src2_valid = v2;
        bus.disp_src2_tag   = t2;
        bus.disp_src2_data  = d2;
        bus.disp_rd_tag     = rd;
        bus.disp_imm        = imm;
    endtask

    task automatic cdb(input int ch, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
        bus.cdb_valid[ch]               = 1'b1;
        bus.cdb_tag[ch*TAG_W +: TAG_W]  = t;
        bus.cdb_data[ch*XLEN +: XLEN]   = d;
    endtask

    task automatic push(input op_t op, input logic [2:0] f3, input logic f7,
                        input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2,
                        input logic [XLEN-1:0] imm, input logic [TAG_W-1:0] tag);
        exp_t e;
        e.op = op; e.funct3 = f3; e.funct7 = f7;
        e.src1 = s1; e.src2 = s2; e.imm = imm; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Every accepted issue must match the next queued expectation in order.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.iss_valid && bus.iss_ready) begin
            mon_act.op     = bus.iss_op;
            mon_act.funct3 = bus.iss_funct3;
            mon_act.funct7 = bus.iss_funct7;
            mon_act.src1   = bus.iss_src1_data;
            mon_act.src2   = bus.iss_src2_data;
            mon_act.imm    = bus.iss_imm;
            mon_act.tag    = bus.iss_tag;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: got %h expected no issue", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL issue_payload: got %h expected %h", mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        idle_inputs();
        bus.iss_ready = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_occ", occupancy, 0);
        chk("rst_disp_ready", bus.disp_ready, 1);
        chk("rst_iss_valid", bus.iss_valid, 0);
        chk("rst_iss_data", bus.iss_src1_data, 0);
        step(); step();
        rst = 1'b1;

        // both operands ready: issue one cycle after dispatch
        bus.iss_ready = 1'b1;
        disp(OP_ARITH, 0, 0, 1, 0, 5, 1, 0, 7, 2, 0);
        push(OP_ARITH, 0, 0, 5, 7, 0, 2);
        step(); idle_inputs();
        chk("t1_iss_valid", bus.iss_valid, 1);
        chk("t1_occ", occupancy, 1);
        chk("t1_iss_tag", bus.iss_tag, 2);
        step();
        chk("t1_occ_drain", occupancy, 0);
        chk("t1_iss_idle", bus.iss_valid, 0);

        // src1 pending on tag 3, woken by CDB channel 1
        disp(OP_LOAD, 2, 0, 0, 3, 0, 1, 0, 9, 5, 32'h10);
        step(); idle_inputs();
        chk("t2_no_issue", bus.iss_valid, 0);
        chk("t2_occ", occupancy, 1);
        cdb(1, 3, 32'hDEAD);
        push(OP_LOAD, 2, 0, 32'hDEAD, 9, 32'h10, 5);
        step(); idle_inputs();
        chk("t2_wake_valid", bus.iss_valid, 1);
        chk("t2_wake_data", bus.iss_src1_data, 32'hDEAD);
        step();
        chk("t2_occ_drain", occupancy, 0);

        // dispatch bypass: tag 4 broadcast on channel 0 in the dispatch cycle
        disp(OP_ARITH_IMM, 1, 1, 1, 0, 1, 0, 4, 0, 6, 0);
        cdb(0, 4, 32'h11);
        push(OP_ARITH_IMM, 1, 1, 1, 32'h11, 0, 6);
        step(); idle_inputs();
        chk("t3_bypass_valid", bus.iss_valid, 1);
        chk("t3_bypass_data", bus.iss_src2_data, 32'h11);
        step();
        chk("t3_occ_drain", occupancy, 0);

        // fill all four entries with pending src1
        bus.iss_ready = 1'b0;
        disp(OP_STORE,  0, 0, 0, 1, 0, 1, 0, 32'h100, 4, 0); step();
        disp(OP_BRANCH, 0, 0, 0, 2, 0, 1, 0, 32'h200, 5, 0); step();
        disp(OP_JAL,    0, 0, 0, 3, 0, 1, 0, 32'h300, 6, 0); step();
        disp(OP_JALR,   0, 0, 0, 5, 0, 1, 0, 32'h400, 3, 0); step();
        chk("t4_occ_full", occupancy, 4);
        chk("t4_ready_low", bus.disp_ready, 0);
        chk("t4_no_issue", bus.iss_valid, 0);
        disp(OP_LUI, 0, 0, 0, 6, 0, 1, 0, 0, 7, 0);
        step();
        chk("t4_fifth_ignored", occupancy, 4);
        idle_inputs();
        cdb(0, 1, 32'hA0);
        cdb(1, 2, 32'hB0);
        push(OP_STORE,  0, 0, 32'hA0, 32'h100, 0, 4);
        push(OP_BRANCH, 0, 0, 32'hB0, 32'h200, 0, 5);
        step(); idle_inputs();
        chk("t4_wake_valid", bus.iss_valid, 1);
        chk("t4_wake_tag", bus.iss_tag, 4);
        bus.iss_ready = 1'b1;
        disp(OP_LUI, 3, 0, 1, 0, 32'h21, 1, 0, 32'h22, 1, 32'h5000);
        chk("t4_ready_still_low", bus.disp_ready, 0);
        step();
        chk("t4_occ_after_issue", occupancy, 3);
        chk("t4_ready_back", bus.disp_ready, 1);
        chk("t4_next_tag", bus.iss_tag, 5);
        push(OP_LUI, 3, 0, 32'h21, 32'h22, 32'h5000, 1);
        step(); idle_inputs();
        chk("t4_occ_swap", occupancy, 3);
        chk("t4_ready_swap", bus.disp_ready, 1);
        chk("t4_reused_slot_tag", bus.iss_tag, 1);
        step();
        chk("t4_occ_left", occupancy, 2);

        // entry 2 held by the lock while lower entry 0 becomes ready
        bus.iss_ready = 1'b0;
        disp(OP_ARITH, 7, 1, 0, 7, 0, 1, 0, 32'h77, 2, 32'h9);
        step(); idle_inputs();
        cdb(0, 3, 32'hC0);
        step(); idle_inputs();
        chk("t5_sel_valid", bus.iss_valid, 1);
        chk("t5_sel_tag", bus.iss_tag, 6);
        cdb(1, 7, 32'h70);
        step(); idle_inputs();
        for (int k = 0; k < 3; k++) begin
            chk("t5_lock_tag", bus.iss_tag, 6);
            chk("t5_lock_data", bus.iss_src1_data, 32'hC0);
            if (k < 2) step();
        end
        push(OP_JAL,   0, 0, 32'hC0, 32'h300, 0, 6);
        push(OP_ARITH, 7, 1, 32'h70, 32'h77, 32'h9, 2);
        bus.iss_ready = 1'b1;
        step();
        chk("t5_after_lock_tag", bus.iss_tag, 2);
        step();
        chk("t5_occ", occupancy, 1);

        // flush overrides a same-cycle dispatch
        bus.iss_ready = 1'b0;
        disp(OP_LOAD,  0, 0, 0, 1, 0, 1, 0, 0, 4, 0); step();
        disp(OP_STORE, 0, 0, 1, 0, 5, 1, 0, 6, 5, 0); step();
        idle_inputs();
        chk("t6_occ_pre", occupancy, 3);
        chk("t6_valid_pre", bus.iss_valid, 1);
        flush = 1'b1;
        disp(OP_LUI, 0, 0, 1, 0, 32'h31, 1, 0, 32'h32, 7, 0);
        step();
        flush = 1'b0;
        idle_inputs();
        chk("t6_flush_occ", occupancy, 0);
        chk("t6_flush_valid", bus.iss_valid, 0);
        chk("t6_flush_ready", bus.disp_ready, 1);
        bus.iss_ready = 1'b1;
        step(); step();
        chk("t6_drop_occ", occupancy, 0);
        chk("t6_drop_valid", bus.iss_valid, 0);

        // asynchronous reset mid-operation
        bus.iss_ready = 1'b0;
        disp(OP_ARITH, 0, 0, 1, 0, 32'hAB, 1, 0, 32'hCD, 3, 0);
        step(); idle_inputs();
        chk("t7_pre_valid", bus.iss_valid, 1);
        chk("t7_pre_occ", occupancy, 1);
        #2 rst = 1'b0;
        #1;
        chk("t7_rst_occ", occupancy, 0);
        chk("t7_rst_valid", bus.iss_valid, 0);
        chk("t7_rst_ready", bus.disp_ready, 1);
        chk("t7_rst_data", bus.iss_src1_data, 0);
        chk("t7_rst_tag", bus.iss_tag, 0);
        step();
        chk("end_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
